// File: rtl/regfile_rd2w1_pkg.sv
//==============================================================================
// Package    : cpu_pkg
// Description: Shared CPU widths and types for the register file slice.
//              DATA_W     - default register data width
//              REG_ADDR_W - default register address width
//              REG_DEPTH  - default number of registers
//              word_t, reg_addr_t - convenience types for the defaults
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 2;
   localparam int REG_DEPTH  = 4;

   typedef logic [DATA_W-1:0]     word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/regfile_rd2w1_if.sv
//==============================================================================
// Interface  : regfile_rd2w1_if
// Description: Write bus plus two read ports (A and B) of the register file.
//   we, waddr, wdata           - write request (master -> slave)
//   ra_en, ra_addr             - port A read request (master -> slave)
//   ra_data, ra_valid          - port A read response (slave -> master)
//   rb_en, rb_addr             - port B read request (master -> slave)
//   rb_data, rb_valid          - port B read response (slave -> master)
//   Modports: master (requester side), slave (register file side).
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_rd2w1_if
   import cpu_pkg::*;
#(
   parameter int N  = DATA_W,
   parameter int AW = REG_ADDR_W
);

   logic          we;
   logic [AW-1:0] waddr;
   logic [N-1:0]  wdata;

   logic          ra_en;
   logic [AW-1:0] ra_addr;
   logic [N-1:0]  ra_data;
   logic          ra_valid;

   logic          rb_en;
   logic [AW-1:0] rb_addr;
   logic [N-1:0]  rb_data;
   logic          rb_valid;

   modport master (
      output we, waddr, wdata,
      output ra_en, ra_addr,
      input  ra_data, ra_valid,
      output rb_en, rb_addr,
      input  rb_data, rb_valid
   );

   modport slave (
      input  we, waddr, wdata,
      input  ra_en, ra_addr,
      output ra_data, ra_valid,
      input  rb_en, rb_addr,
      output rb_data, rb_valid
   );

endinterface : regfile_rd2w1_if

`default_nettype wire

// File: rtl/regfile_rd2w1_read_port.sv
//==============================================================================
// Module     : regfile_read_port
// Description: One registered read port of the register file. Checks the
//              address range, optionally forwards same-edge write data, and
//              registers data plus a one-cycle valid pulse.
//   clk      in  clock (posedge)
//   rst      in  asynchronous active-high reset
//   en_i     in  read request
//   addr_i   in  read address
//   mem_i    in  full storage array (pre-edge contents)
//   we_i, waddr_i, wdata_i  in  write bus (only with REGFILE_BYPASS_EN)
//   data_o   out registered read data (holds when no request)
//   valid_o  out one-cycle valid pulse
// Build macro: REGFILE_BYPASS_EN - enables write-through forwarding.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_read_port
   import cpu_pkg::*;
#(
   parameter int N     = DATA_W,
   parameter int DEPTH = REG_DEPTH,
   parameter int AW    = REG_ADDR_W
) (
   input  wire logic          clk,
   input  wire logic          rst,
`ifdef REGFILE_BYPASS_EN
   input  wire logic          we_i,
   input  wire logic [AW-1:0] waddr_i,
   input  wire logic [N-1:0]  wdata_i,
`endif
   input  wire logic          en_i,
   input  wire logic [AW-1:0] addr_i,
   input  wire logic [N-1:0]  mem_i [DEPTH],
   output logic [N-1:0]       data_o,
   output logic               valid_o
);

   // DEPTH widened by one bit so that DEPTH == 2**AW is still representable.
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic          in_range;
   logic [N-1:0]  data_d, data_q;
   logic          valid_d, valid_q;

   assign in_range = ({1'b0, addr_i} < DEPTH_C);

   always_comb begin
      data_d  = data_q;
      valid_d = en_i;
      if (en_i) begin
         if (in_range) begin
            data_d = mem_i[addr_i];
`ifdef REGFILE_BYPASS_EN
            // Same-edge write to the address being read: return the new value.
            if (we_i && (waddr_i == addr_i)) begin
               data_d = wdata_i;
            end
`endif
         end else begin
            data_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule : regfile_read_port

`default_nettype wire

// File: rtl/regfile_rd2w1.sv
//==============================================================================
// Module     : regfile_rd2w1
// Description: Register file with one write port and two independent
//              registered read ports (1-cycle latency, valid pulse).
//   clk   in  clock (posedge)
//   rst   in  asynchronous active-high reset, clears storage and outputs
//   bus   slave modport of regfile_rd2w1_if (write bus, read ports A and B)
// Parameters: N (data width), DEPTH (entries, >= 2, any value),
//             AW (address width, 2**AW >= DEPTH).
// Build macro: REGFILE_BYPASS_EN - read/write collisions forward wdata.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_rd2w1
   import cpu_pkg::*;
#(
   parameter int N     = DATA_W,
   parameter int DEPTH = REG_DEPTH,
   parameter int AW    = REG_ADDR_W
) (
   input  wire logic       clk,
   input  wire logic       rst,
   regfile_rd2w1_if.slave  bus
);

   logic [N-1:0] mem_q [DEPTH];

   logic [N-1:0] ra_data_w, rb_data_w;
   logic         ra_valid_w, rb_valid_w;

   // Per-entry write decode. Addresses >= DEPTH match no entry, so such
   // writes fall away without any explicit range check.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_q[i] <= '0;
         end else if (bus.we && (bus.waddr == AW'(i))) begin
            mem_q[i] <= bus.wdata;
         end
      end
   end

   regfile_read_port #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_port_a (
      .clk     (clk),
      .rst     (rst),
`ifdef REGFILE_BYPASS_EN
      .we_i    (bus.we),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
`endif
      .en_i    (bus.ra_en),
      .addr_i  (bus.ra_addr),
      .mem_i   (mem_q),
      .data_o  (ra_data_w),
      .valid_o (ra_valid_w)
   );

   regfile_read_port #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_port_b (
      .clk     (clk),
      .rst     (rst),
`ifdef REGFILE_BYPASS_EN
      .we_i    (bus.we),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
`endif
      .en_i    (bus.rb_en),
      .addr_i  (bus.rb_addr),
      .mem_i   (mem_q),
      .data_o  (rb_data_w),
      .valid_o (rb_valid_w)
   );

   assign bus.ra_data  = ra_data_w;
   assign bus.ra_valid = ra_valid_w;
   assign bus.rb_data  = rb_data_w;
   assign bus.rb_valid = rb_valid_w;

endmodule : regfile_rd2w1

`default_nettype wire

// File: tb/tb_regfile_rd2w1.sv
//==============================================================================
// Module     : tb_regfile_rd2w1
// Description: Self-checking bench for regfile_rd2w1 built with DEPTH=3 so
//              that address 3 is out of range (non-power-of-two depth).
//              Expected outputs are queued when a cycle is driven and popped
//              one edge later. Works with or without REGFILE_BYPASS_EN.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_rd2w1;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   regfile_rd2w1_if #(.N(8), .AW(2)) bus ();

   regfile_rd2w1 #(.N(8), .DEPTH(3), .AW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       we;
      logic [1:0] waddr;
      logic [7:0] wdata;
      logic       ra_en;
      logic [1:0] ra_addr;
      logic       rb_en;
      logic [1:0] rb_addr;
      logic       ea_v;
      logic [7:0] ea_d;
      logic       eb_v;
      logic [7:0] eb_d;
   } vec_t;

   typedef struct {
      logic       a_v;
      logic [7:0] a_d;
      logic       b_v;
      logic [7:0] b_d;
      string      tag;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[15];

   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd,
                               logic rae, logic [1:0] raa,
                               logic rbe, logic [1:0] rba,
                               logic eav, logic [7:0] ead,
                               logic ebv, logic [7:0] ebd);
      vec_t v;
      v.we = we; v.waddr = wa; v.wdata = wd;
      v.ra_en = rae; v.ra_addr = raa; v.rb_en = rbe; v.rb_addr = rba;
      v.ea_v = eav; v.ea_d = ead; v.eb_v = ebv; v.eb_d = ebd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.we      = v.we;
      bus.waddr   = v.waddr;
      bus.wdata   = v.wdata;
      bus.ra_en   = v.ra_en;
      bus.ra_addr = v.ra_addr;
      bus.rb_en   = v.rb_en;
      bus.rb_addr = v.rb_addr;
   endtask

   // Drive one cycle, queue its expectation, sample #1 after the edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      e.a_v = v.ea_v; e.a_d = v.ea_d; e.b_v = v.eb_v; e.b_d = v.eb_d; e.tag = tag;
      drive(v);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
      end else begin
         e = sb.pop_front();
         chk({e.tag, " ra_valid"}, {7'd0, bus.ra_valid}, {7'd0, e.a_v});
         chk({e.tag, " ra_data"},  bus.ra_data,          e.a_d);
         chk({e.tag, " rb_valid"}, {7'd0, bus.rb_valid}, {7'd0, e.b_v});
         chk({e.tag, " rb_data"},  bus.rb_data,          e.b_d);
      end
   endtask

   task automatic idle();
      drive(mk(0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 0, 8'h00, 0, 8'h00));
   endtask

   initial begin
      // Each row: write, read A, read B, then expected A/B one edge later.
      tbl[0]  = mk(1, 2'd2, 8'hA5, 0, 2'd0, 0, 2'd0, 0, 8'h00, 0, 8'h00);
      tbl[1]  = mk(0, 2'd0, 8'h00, 1, 2'd2, 0, 2'd0, 1, 8'hA5, 0, 8'h00);
      tbl[2]  = mk(0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 0, 8'hA5, 0, 8'h00);
      tbl[3]  = mk(1, 2'd1, 8'h3C, 0, 2'd0, 0, 2'd0, 0, 8'hA5, 0, 8'h00);
      tbl[4]  = mk(1, 2'd2, 8'hC3, 0, 2'd0, 0, 2'd0, 0, 8'hA5, 0, 8'h00);
      tbl[5]  = mk(0, 2'd0, 8'h00, 1, 2'd1, 1, 2'd2, 1, 8'h3C, 1, 8'hC3);
      tbl[6]  = mk(0, 2'd0, 8'h00, 1, 2'd2, 1, 2'd2, 1, 8'hC3, 1, 8'hC3);
      tbl[7]  = mk(1, 2'd3, 8'h77, 1, 2'd0, 1, 2'd1, 1, 8'h00, 1, 8'h3C);
      tbl[8]  = mk(0, 2'd0, 8'h00, 1, 2'd3, 1, 2'd2, 1, 8'h00, 1, 8'hC3);
      tbl[9]  = mk(0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1, 1, 8'h00, 1, 8'h3C);
      tbl[10] = mk(1, 2'd0, 8'h11, 0, 2'd0, 0, 2'd0, 0, 8'h00, 0, 8'h3C);
      tbl[11] = mk(1, 2'd0, 8'h22, 1, 2'd0, 1, 2'd0,
                   1, BYP ? 8'h22 : 8'h11, 1, BYP ? 8'h22 : 8'h11);
      tbl[12] = mk(0, 2'd0, 8'h00, 1, 2'd0, 0, 2'd0,
                   1, 8'h22, 0, BYP ? 8'h22 : 8'h11);
      tbl[13] = mk(1, 2'd1, 8'h5A, 1, 2'd2, 1, 2'd1,
                   1, 8'hC3, 1, BYP ? 8'h5A : 8'h3C);
      tbl[14] = mk(0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd1, 0, 8'hC3, 1, 8'h5A);

      // Reset held: writes of 0xFF and reads must have no visible effect.
      rst = 1'b1;
      idle();
      for (int i = 0; i < 4; i++) begin
         drive(mk(1, 2'(i), 8'hFF, 1, 2'(i), 1, 2'(i), 0, 8'h00, 0, 8'h00));
         @(posedge clk);
         #1;
         chk($sformatf("reset%0d ra_valid", i), {7'd0, bus.ra_valid}, 8'h00);
         chk($sformatf("reset%0d ra_data", i),  bus.ra_data,          8'h00);
         chk($sformatf("reset%0d rb_valid", i), {7'd0, bus.rb_valid}, 8'h00);
         chk($sformatf("reset%0d rb_data", i),  bus.rb_data,          8'h00);
      end
      idle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply(mk(0, 2'd0, 8'h00, 1, 2'(i), 1, 2'(i), 1, 8'h00, 1, 8'h00),
               $sformatf("postreset_rd%0d", i));
      end

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset mid-read: a valid pulse is cut short and data clears at once.
      apply(mk(0, 2'd0, 8'h00, 1, 2'd2, 0, 2'd0, 1, 8'hC3, 0, 8'h5A), "preabort");
      drive(mk(0, 2'd0, 8'h00, 1, 2'd1, 0, 2'd0, 0, 8'h00, 0, 8'h00));
      @(posedge clk);
      #1;
      chk("inflight ra_valid", {7'd0, bus.ra_valid}, 8'h01);
      chk("inflight ra_data",  bus.ra_data,          8'h5A);
      rst = 1'b1;
      #1;
      chk("abort ra_valid", {7'd0, bus.ra_valid}, 8'h00);
      chk("abort ra_data",  bus.ra_data,          8'h00);
      chk("abort rb_data",  bus.rb_data,          8'h00);
      idle();
      #1;
      rst = 1'b0;
      apply(mk(0, 2'd0, 8'h00, 1, 2'd1, 1, 2'd2, 1, 8'h00, 1, 8'h00), "cleared_rd");

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #20000;
      $display("FAIL timeout: got no finish, expected finish before 20000");
      $fatal(1);
   end

endmodule : tb_regfile_rd2w1

`default_nettype wire
